irq_encoder_8_3: RTL and testbench

Sequential 8-to-3 priority encoder with request latching and a valid/ready output handshake. It is the encode-side counterpart of the 3-to-8 decoder. Eight one-hot or multi-hot event lines (`d`) are captured into a sticky pending register, masked, and presented one at a time as a 3-bit index (`s`), lowest index first. Each presented index is cleared from the pending register when the consumer accepts it. It sits between event sources and a consumer that drives the decoder with the returned index.

---
 rtl/irq_encoder_8_3_if.sv | 22 ++
 rtl/irq_encoder_8_3.sv | 79 +++++++
 tb/tb_irq_encoder_8_3.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/irq_encoder_8_3_if.sv
// Request/mask/handshake bundle for irq_encoder_8_3.
// The encoder takes the slave modport; event sources and the consumer share the master side.
interface irq_encoder_8_3_if;
  logic [7:0] d;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       ready;
  logic [2:0] s;
  logic       valid;
  logic [7:0] pending;
  logic [7:0] mask;

  modport master (
    output d, mask_we, mask_in, ready,
    input  s, valid, pending, mask
  );

  modport slave (
    input  d, mask_we, mask_in, ready,
    output s, valid, pending, mask
  );
endinterface

// File: rtl/irq_encoder_8_3.sv
// Sequential 8-to-3 priority encoder: sticky pending register, mask, and a
// registered valid/ready output stage presenting the lowest eligible index first.
module irq_encoder_8_3 #(
  parameter logic [7:0] MASK_RESET = 8'h00
) (
  input logic              clk,
  input logic              rst,
  irq_encoder_8_3_if.slave bus
);

  logic [7:0] r_pending;
  logic [7:0] r_mask;
  logic [2:0] r_s;
  logic       r_valid;

  logic       w_acc;
  logic       w_load;
  logic [7:0] w_clr;
  logic [7:0] w_elig;

  // Bit 0 has the highest priority.
  function automatic logic [2:0] f_lowest_idx(input logic [7:0] vec);
    logic [2:0] idx;
    casez (vec)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default:     idx = 3'd0;
    endcase
    return idx;
  endfunction

  // Accept decode, clear vector and eligibility.
  always_comb begin
    w_acc = r_valid & bus.ready;
    if (w_acc) begin
      w_clr = 8'h01 << r_s;
    end else begin
      w_clr = 8'h00;
    end
    w_elig = r_pending & ~w_clr & ~r_mask;
    w_load = ~r_valid | w_acc;
  end

  // Pending and mask registers; a new request on a bit being cleared wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 8'h00;
      r_mask    <= MASK_RESET;
    end else begin
      r_pending <= (r_pending & ~w_clr) | bus.d;
      if (bus.mask_we) begin
        r_mask <= bus.mask_in;
      end
    end
  end

  // Output stage: frozen while a presented index waits for ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_s     <= 3'd0;
    end else if (w_load) begin
      r_valid <= |w_elig;
      r_s     <= f_lowest_idx(w_elig);
    end
  end

  assign bus.s       = r_s;
  assign bus.valid   = r_valid;
  assign bus.pending = r_pending;
  assign bus.mask    = r_mask;

endmodule

// File: tb/tb_irq_encoder_8_3.sv
// Directed bench for irq_encoder_8_3: a vector table for pulse/burst/mask
// sequences plus hand-written backpressure, set-wins and reset-abort cases.
module tb_irq_encoder_8_3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  irq_encoder_8_3_if bus ();

  irq_encoder_8_3 #(.MASK_RESET(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       ready;
    logic       exp_valid;
    logic [2:0] exp_s;
    logic [7:0] exp_pending;
    logic [7:0] exp_mask;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic mwe, input logic [7:0] min, input logic rdy);
    bus.d       = d;
    bus.mask_we = mwe;
    bus.mask_in = min;
    bus.ready   = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [2:0] s,
                         input logic [7:0] p, input logic [7:0] m);
    chk({name, ".valid"},   {7'd0, bus.valid}, {7'd0, v});
    chk({name, ".s"},       {5'd0, bus.s},     {5'd0, s});
    chk({name, ".pending"}, bus.pending,       p);
    chk({name, ".mask"},    bus.mask,          m);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //           d      we    min    rdy   v     s     pend   mask
    vecs[0]  = '{8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h10, 8'h00};
    vecs[1]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 3'd4, 8'h10, 8'h00};
    vecs[2]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[3]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[4]  = '{8'hA4, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'hA4, 8'h00};
    vecs[5]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 3'd2, 8'hA4, 8'h00};
    vecs[6]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 8'hA0, 8'h00};
    vecs[7]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 8'h80, 8'h00};
    vecs[8]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[9]  = '{8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 8'h01};
    vecs[10] = '{8'h03, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h03, 8'h01};
    vecs[11] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h03, 8'h01};
    vecs[12] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h01, 8'h01};
    vecs[13] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h01, 8'h01};
    vecs[14] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h01, 8'h00};
    vecs[15] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h01, 8'h00};
    vecs[16] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};

    // Reset must override d, mask_we and ready.
    rst = 1'b1;
    drive(8'hFF, 1'b1, 8'hFF, 1'b1);
    tick();
    tick();
    chk_out("reset", 1'b0, 3'd0, 8'h00, 8'h00);
    rst = 1'b0;
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    chk_out("post_reset", 1'b0, 3'd0, 8'h00, 8'h00);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].d, vecs[i].mask_we, vecs[i].mask_in, vecs[i].ready);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_s,
              vecs[i].exp_pending, vecs[i].exp_mask);
    end

    // Backpressure: presented index stays frozen, lower arrival does not preempt.
    drive(8'h81, 1'b0, 8'h00, 1'b0);
    tick();
    chk_out("bp_latch", 1'b0, 3'd0, 8'h81, 8'h00);
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("bp_hold%0d", i), 1'b1, 3'd0, 8'h81, 8'h00);
    end
    drive(8'h02, 1'b0, 8'h00, 1'b0);
    tick();
    chk_out("bp_newlow", 1'b1, 3'd0, 8'h83, 8'h00);
    drive(8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    chk_out("bp_acc0", 1'b1, 3'd1, 8'h82, 8'h00);
    tick();
    chk_out("bp_acc1", 1'b1, 3'd7, 8'h80, 8'h00);
    tick();
    chk_out("bp_acc7", 1'b0, 3'd0, 8'h00, 8'h00);

    // Set wins over clear on the accepted bit.
    drive(8'h08, 1'b0, 8'h00, 1'b0);
    tick();
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    chk_out("sw_present", 1'b1, 3'd3, 8'h08, 8'h00);
    drive(8'h08, 1'b0, 8'h00, 1'b1);
    tick();
    chk_out("sw_collide", 1'b0, 3'd0, 8'h08, 8'h00);
    drive(8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    chk_out("sw_again", 1'b1, 3'd3, 8'h08, 8'h00);
    tick();
    chk_out("sw_done", 1'b0, 3'd0, 8'h00, 8'h00);

    // Reset while a request is held drops valid without an accept.
    drive(8'h01, 1'b0, 8'h00, 1'b0);
    tick();
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    chk_out("rh_held", 1'b1, 3'd0, 8'h01, 8'h00);
    rst = 1'b1;
    drive(8'hFF, 1'b1, 8'h5A, 1'b1);
    tick();
    chk_out("rh_reset", 1'b0, 3'd0, 8'h00, 8'h00);
    rst = 1'b0;
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    chk_out("rh_after", 1'b0, 3'd0, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
